// File: rtl/qm_writeback_pkg.sv
// Shared widths and types for the register-file write-back path.
// Default parameters for the top block and its FIFO live here.
package qm_writeback_pkg;

   localparam int unsigned QM_DATA_W   = 32;
   localparam int unsigned QM_RADDR_W  = 5;
   localparam int unsigned QM_WB_DEPTH = 4;

   localparam logic [QM_RADDR_W-1:0] QM_REG_ZERO = 5'd0;

   // Which producer wins the single enqueue slot this cycle.
   typedef enum logic [1:0] {
      SrcNone,
      SrcMem,
      SrcAlu
   } wb_src_e;

endpackage

// File: rtl/qm_wb_fifo.sv
// Write-back result FIFO: storage, pointers and occupancy count.
// Entries are also presented oldest-first so the owner can search them for pending writes.
module qm_wb_fifo
   import qm_writeback_pkg::*;
#(
   parameter int unsigned DEPTH  = QM_WB_DEPTH,
   parameter int unsigned DATA_W = QM_DATA_W,
   parameter int unsigned ADDR_W = QM_RADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_wa,
   input  logic [DATA_W-1:0]        push_wd,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ADDR_W-1:0]        head_wa,
   output logic [DATA_W-1:0]        head_wd,
   output logic [DEPTH-1:0]         age_valid,
   output logic [ADDR_W-1:0]        age_wa [DEPTH],
   output logic [DATA_W-1:0]        age_wd [DEPTH]
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [ADDR_W-1:0] wa_q [DEPTH];
   logic [ADDR_W-1:0] wa_d [DEPTH];
   logic [DATA_W-1:0] wd_q [DEPTH];
   logic [DATA_W-1:0] wd_d [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;

   always_comb begin
      wa_d     = wa_q;
      wd_d     = wd_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wa_d[wr_ptr_q] = push_wa;
         wd_d[wr_ptr_q] = push_wd;
         wr_ptr_d       = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            wa_q[i] <= '0;
            wd_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Index 0 is the oldest live entry; higher indices are younger.
   always_comb begin
      logic [PtrW-1:0] idx;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx          = rd_ptr_q + PtrW'(i);
         age_valid[i] = CntW'(i) < count_q;
         age_wa[i]    = wa_q[idx];
         age_wd[i]    = wd_q[idx];
      end
   end

   assign count   = count_q;
   assign head_wa = wa_q[rd_ptr_q];
   assign head_wd = wd_q[rd_ptr_q];

endmodule

// File: rtl/qm_writeback.sv
// Register-file write port driver: arbitrates load/ALU results into a FIFO, drains one write
// per cycle, and reports the youngest pending value for the two decode read addresses.
module qm_writeback
   import qm_writeback_pkg::*;
#(
   parameter int unsigned DEPTH  = QM_WB_DEPTH,
   parameter int unsigned DATA_W = QM_DATA_W,
   parameter int unsigned ADDR_W = QM_RADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_wa,
   input  logic [DATA_W-1:0] mem_wd,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_wa,
   input  logic [DATA_W-1:0] alu_wd,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              hit1,
   output logic              hit2,
   output logic [DATA_W-1:0] fwd1,
   output logic [DATA_W-1:0] fwd2,
   output logic              empty
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(QM_REG_ZERO);

   wb_src_e           src;
   logic              full;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_wa;
   logic [DATA_W-1:0] push_wd;
   logic [CntW-1:0]   count;
   logic [ADDR_W-1:0] head_wa;
   logic [DATA_W-1:0] head_wd;
   logic [DEPTH-1:0]  age_valid;
   logic [ADDR_W-1:0] age_wa [DEPTH];
   logic [DATA_W-1:0] age_wd [DEPTH];

   logic              we3_q, we3_d;
   logic [ADDR_W-1:0] wa3_q, wa3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;

   // Ready looks only at the registered count, so a full FIFO never passes a result through.
   always_comb begin
      full      = (count == CntW'(DEPTH));
      mem_ready = !full;
      alu_ready = !full && !mem_valid;
      src       = SrcNone;
      if (mem_valid && mem_ready) begin
         src = SrcMem;
      end else if (alu_valid && alu_ready) begin
         src = SrcAlu;
      end
      unique case (src)
         SrcMem: begin
            push_wa = mem_wa;
            push_wd = mem_wd;
         end
         SrcAlu: begin
            push_wa = alu_wa;
            push_wd = alu_wd;
         end
         default: begin
            push_wa = '0;
            push_wd = '0;
         end
      endcase
      // Writes to r0 are accepted and then dropped.
      push = (src != SrcNone) && (push_wa != RegZero);
      pop  = (count != '0);
   end

   qm_wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_wa   (push_wa),
      .push_wd   (push_wd),
      .pop       (pop),
      .count     (count),
      .head_wa   (head_wa),
      .head_wd   (head_wd),
      .age_valid (age_valid),
      .age_wa    (age_wa),
      .age_wd    (age_wd)
   );

   always_comb begin
      we3_d = pop;
      wa3_d = pop ? head_wa : wa3_q;
      wd3_d = pop ? head_wd : wd3_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we3_q <= 1'b0;
         wa3_q <= '0;
         wd3_q <= '0;
      end else begin
         we3_q <= we3_d;
         wa3_q <= wa3_d;
         wd3_q <= wd3_d;
      end
   end

   // Oldest source first so later (younger) matches override earlier ones.
   always_comb begin
      hit1 = 1'b0;
      fwd1 = '0;
      hit2 = 1'b0;
      fwd2 = '0;
      if (we3_q && (wa3_q == ra1)) begin
         hit1 = 1'b1;
         fwd1 = wd3_q;
      end
      if (we3_q && (wa3_q == ra2)) begin
         hit2 = 1'b1;
         fwd2 = wd3_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && (age_wa[i] == ra1)) begin
            hit1 = 1'b1;
            fwd1 = age_wd[i];
         end
         if (age_valid[i] && (age_wa[i] == ra2)) begin
            hit2 = 1'b1;
            fwd2 = age_wd[i];
         end
      end
      if (ra1 == RegZero) begin
         hit1 = 1'b0;
         fwd1 = '0;
      end
      if (ra2 == RegZero) begin
         hit2 = 1'b0;
         fwd2 = '0;
      end
   end

   assign we3   = we3_q;
   assign wa3   = wa3_q;
   assign wd3   = wd3_q;
   assign empty = (count == '0) && !we3_q;

endmodule

// File: tb/tb_qm_writeback.sv
// Directed bench for qm_writeback: per-cycle vector table plus a hand-written async reset sequence.
module tb_qm_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, mem_ready, alu_valid, alu_ready;
   logic [4:0]  mem_wa, alu_wa, wa3, ra1, ra2;
   logic [31:0] mem_wd, alu_wd, wd3, fwd1, fwd2;
   logic        we3, hit1, hit2, empty;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   qm_writeback dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_wa    (mem_wa),
      .mem_wd    (mem_wd),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_wa    (alu_wa),
      .alu_wd    (alu_wd),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .ra1       (ra1),
      .ra2       (ra2),
      .hit1      (hit1),
      .hit2      (hit2),
      .fwd1      (fwd1),
      .fwd2      (fwd2),
      .empty     (empty)
   );

   typedef struct {
      logic [31:0] mv, mwa, mwd, av, awa, awd, ra1, ra2;
      logic [31:0] emr, ear, ewe, ewa, ewd, eh1, ef1, eh2, ef2, eempty;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic [31:0] mv, mwa, mwd, av, awa, awd, ra1, ra2,
      input logic [31:0] emr, ear, ewe, ewa, ewd, eh1, ef1, eh2, ef2, eempty);
      vec_t v;
      v.mv = mv;  v.mwa = mwa; v.mwd = mwd; v.av = av; v.awa = awa; v.awd = awd;
      v.ra1 = ra1; v.ra2 = ra2;
      v.emr = emr; v.ear = ear; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
      v.eh1 = eh1; v.ef1 = ef1; v.eh2 = eh2; v.ef2 = ef2; v.eempty = eempty;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      mem_valid = v.mv[0];
      mem_wa    = v.mwa[4:0];
      mem_wd    = v.mwd;
      alu_valid = v.av[0];
      alu_wa    = v.awa[4:0];
      alu_wd    = v.awd;
      ra1       = v.ra1[4:0];
      ra2       = v.ra2[4:0];
   endtask

   task automatic drive_idle();
      mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
      alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
      ra1 = '0; ra2 = '0;
   endtask

   task automatic check_vec(input int k, input vec_t v);
      chk($sformatf("v%0d mem_ready", k), {31'd0, mem_ready}, v.emr);
      chk($sformatf("v%0d alu_ready", k), {31'd0, alu_ready}, v.ear);
      chk($sformatf("v%0d we3", k), {31'd0, we3}, v.ewe);
      chk($sformatf("v%0d wa3", k), {27'd0, wa3}, v.ewa);
      chk($sformatf("v%0d wd3", k), wd3, v.ewd);
      chk($sformatf("v%0d hit1", k), {31'd0, hit1}, v.eh1);
      chk($sformatf("v%0d fwd1", k), fwd1, v.ef1);
      chk($sformatf("v%0d hit2", k), {31'd0, hit2}, v.eh2);
      chk($sformatf("v%0d fwd2", k), fwd2, v.ef2);
      chk($sformatf("v%0d empty", k), {31'd0, empty}, v.eempty);
   endtask

   initial begin
      // Each row: inputs for one cycle, then outputs seen before that cycle's rising edge.
      //             mv mwa mwd  av awa awd           ra1 ra2
      //             mr ar we wa3 wd3          h1 f1           h2 f2    empty
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            0, 0,
                        1, 1, 0, 0, 0,            0, 0,            0, 0,     1));
      // single ALU result
      vecs.push_back(mk(0, 0, 0,    1, 3, 32'hDEADBEEF, 0, 0,
                        1, 1, 0, 0, 0,            0, 0,            0, 0,     1));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            3, 0,
                        1, 1, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            3, 0,
                        1, 1, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            3, 0,
                        1, 1, 0, 3, 32'hDEADBEEF, 0, 0,            0, 0,     1));
      // mem/ALU collision
      vecs.push_back(mk(1, 4, 32'h11, 1, 5, 32'h22,     4, 0,
                        1, 0, 0, 3, 32'hDEADBEEF, 0, 0,            0, 0,     1));
      vecs.push_back(mk(0, 0, 0,    1, 5, 32'h22,       4, 5,
                        1, 1, 0, 3, 32'hDEADBEEF, 1, 32'h11,       0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            4, 5,
                        1, 1, 1, 4, 32'h11,       1, 32'h11,       1, 32'h22, 0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            4, 5,
                        1, 1, 1, 5, 32'h22,       0, 0,            1, 32'h22, 0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            0, 0,
                        1, 1, 0, 5, 32'h22,       0, 0,            0, 0,     1));
      // youngest-match forwarding
      vecs.push_back(mk(0, 0, 0,    1, 7, 32'h1,        7, 0,
                        1, 1, 0, 5, 32'h22,       0, 0,            0, 0,     1));
      vecs.push_back(mk(0, 0, 0,    1, 7, 32'h2,        7, 0,
                        1, 1, 0, 5, 32'h22,       1, 32'h1,        0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            7, 0,
                        1, 1, 1, 7, 32'h1,        1, 32'h2,        0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            7, 0,
                        1, 1, 1, 7, 32'h2,        1, 32'h2,        0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            7, 0,
                        1, 1, 0, 7, 32'h2,        0, 0,            0, 0,     1));
      // r0 discard on both paths
      vecs.push_back(mk(0, 0, 0,    1, 0, 32'hFFFFFFFF, 0, 0,
                        1, 1, 0, 7, 32'h2,        0, 0,            0, 0,     1));
      vecs.push_back(mk(1, 0, 32'h5, 0, 0, 0,           0, 0,
                        1, 0, 0, 7, 32'h2,        0, 0,            0, 0,     1));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            0, 0,
                        1, 1, 0, 7, 32'h2,        0, 0,            0, 0,     1));
      // DEPTH+1 back-to-back ALU results across pointer wrap
      vecs.push_back(mk(0, 0, 0,    1, 1, 32'hA1,       0, 0,
                        1, 1, 0, 7, 32'h2,        0, 0,            0, 0,     1));
      vecs.push_back(mk(0, 0, 0,    1, 2, 32'hA2,       1, 0,
                        1, 1, 0, 7, 32'h2,        1, 32'hA1,       0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    1, 3, 32'hA3,       0, 0,
                        1, 1, 1, 1, 32'hA1,       0, 0,            0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    1, 4, 32'hA4,       0, 0,
                        1, 1, 1, 2, 32'hA2,       0, 0,            0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    1, 5, 32'hA5,       0, 0,
                        1, 1, 1, 3, 32'hA3,       0, 0,            0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            4, 5,
                        1, 1, 1, 4, 32'hA4,       1, 32'hA4,       1, 32'hA5, 0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            0, 0,
                        1, 1, 1, 5, 32'hA5,       0, 0,            0, 0,     0));
      vecs.push_back(mk(0, 0, 0,    0, 0, 0,            0, 0,
                        1, 1, 0, 5, 32'hA5,       0, 0,            0, 0,     1));

      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k]);
         #1;
         check_vec(k, vecs[k]);
         @(negedge clk);
      end

      // Async reset with a write on the port and another result buffered.
      drive_idle();
      alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h99;
      @(negedge clk);
      alu_wa = 5'd10; alu_wd = 32'hAA;
      @(negedge clk);
      drive_idle();
      ra1 = 5'd10;
      #1;
      chk("pre-reset we3", {31'd0, we3}, 32'd1);
      chk("pre-reset wa3", {27'd0, wa3}, 32'd9);
      chk("pre-reset hit1", {31'd0, hit1}, 32'd1);
      chk("pre-reset fwd1", fwd1, 32'hAA);
      #1 reset = 1'b1;
      #1;
      chk("async we3", {31'd0, we3}, 32'd0);
      chk("async wa3", {27'd0, wa3}, 32'd0);
      chk("async wd3", wd3, 32'd0);
      chk("async empty", {31'd0, empty}, 32'd1);
      chk("async hit1", {31'd0, hit1}, 32'd0);
      chk("async fwd1", fwd1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post-reset c%0d we3", c), {31'd0, we3}, 32'd0);
         chk($sformatf("post-reset c%0d empty", c), {31'd0, empty}, 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
